// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Program-counter generator for the single-cycle datapath.
//               Holds the PC register and selects the next fetch address from
//               sequential fetch, conditional branch, absolute jump, register
//               jump, return-address-stack (RAS) return or exception redirect.
//               Linked calls push pc+4 onto a circular RAS; returns pop it.
// Ports       :
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous reset, active low
//   stall        in   hold PC and RAS this cycle (exception still redirects)
//   exc_valid    in   exception redirect request
//   exc_vector   in   exception redirect target
//   jump_ctrl    in   00 none, 01 absolute, 10 register, 11 reserved (= none)
//   branch_ctrl  in   001 eq, 010 ne, 011 >=0, 100 <0, 101 >0, 110 <=0
//   zero, sign   in   ALU flags (sign = operand positive and nonzero)
//   imm32        in   sign-extended branch offset in words
//   target       in   26-bit absolute jump index
//   reg_target   in   register jump offset
//   link, ret    in   push on absolute jump / pop on register jump
//   pc           out  current PC (registered)
//   npc          out  next PC (combinational)
//   ras_empty    out  RAS holds no entries
//   ras_full     out  RAS holds RAS_DEPTH entries
//   ras_overflow out  sticky: a push overwrote the oldest entry
// Revision    : 1.0  initial release
// ============================================================================
module pc_unit #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_PC  = 32'h0000_3000,
  parameter logic [WIDTH-1:0]   JUMP_BASE = 32'h0000_3000,
  parameter int                 RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              exc_valid,
  input  logic [WIDTH-1:0]  exc_vector,
  input  logic [1:0]        jump_ctrl,
  input  logic [2:0]        branch_ctrl,
  input  logic              zero,
  input  logic              sign,
  input  logic [WIDTH-1:0]  imm32,
  input  logic [25:0]       target,
  input  logic [WIDTH-1:0]  reg_target,
  input  logic              link,
  input  logic              ret,
  output logic [WIDTH-1:0]  pc,
  output logic [WIDTH-1:0]  npc,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow
);

  localparam int                c_PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int                c_CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(RAS_DEPTH);

  localparam logic [1:0] c_JMP_ABS = 2'b01;
  localparam logic [1:0] c_JMP_REG = 2'b10;

  localparam logic [2:0] c_BR_EQ = 3'b001;
  localparam logic [2:0] c_BR_NE = 3'b010;
  localparam logic [2:0] c_BR_GE = 3'b011;
  localparam logic [2:0] c_BR_LT = 3'b100;
  localparam logic [2:0] c_BR_GT = 3'b101;
  localparam logic [2:0] c_BR_LE = 3'b110;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]   r_pc;
  logic [WIDTH-1:0]   r_ras [RAS_DEPTH];
  logic [c_PTR_W-1:0] r_sp;        // next slot to write; top is r_sp-1
  logic [c_CNT_W-1:0] r_count;
  logic               r_overflow;

  // --------------------------------------------------------------------------
  // Address candidates (all modulo 2^WIDTH)
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_branch_tgt;
  logic [WIDTH-1:0] w_jump_abs;
  logic [WIDTH-1:0] w_jump_reg;
  logic [WIDTH-1:0] w_ras_top;
  logic             w_empty;
  logic             w_full;
  logic             w_is_abs;
  logic             w_is_reg;
  logic             w_ret_hit;
  logic             w_taken;
  logic             w_advance;
  logic             w_push;
  logic             w_pop;

  assign w_pc_plus4   = r_pc + WIDTH'(4);
  // Branch offset is relative to the current pc, not pc+4.
  assign w_branch_tgt = r_pc + (imm32 << 2);
  assign w_jump_abs   = JUMP_BASE + (WIDTH'(target) << 2);
  assign w_jump_reg   = JUMP_BASE + reg_target;
  assign w_ras_top    = r_ras[r_sp - c_PTR_ONE];

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == c_CNT_MAX);
  assign w_is_abs = (jump_ctrl == c_JMP_ABS);
  assign w_is_reg = (jump_ctrl == c_JMP_REG);
  // A return on an empty stack silently degrades to a plain register jump.
  assign w_ret_hit = w_is_reg & ret & ~w_empty;

  always_comb begin
    w_taken = 1'b0;
    case (branch_ctrl)
      c_BR_EQ: w_taken = zero;
      c_BR_NE: w_taken = ~zero;
      c_BR_GE: w_taken = zero | sign;
      c_BR_LT: w_taken = ~zero & ~sign;
      c_BR_GT: w_taken = ~zero & sign;
      c_BR_LE: w_taken = zero | ~sign;
      default: w_taken = 1'b0;
    endcase
  end

  // Next-address priority: exception, absolute jump, RAS return,
  // register jump, taken branch, sequential.
  always_comb begin
    npc = w_pc_plus4;
    if (exc_valid)      npc = exc_vector;
    else if (w_is_abs)  npc = w_jump_abs;
    else if (w_ret_hit) npc = w_ras_top;
    else if (w_is_reg)  npc = w_jump_reg;
    else if (w_taken)   npc = w_branch_tgt;
  end

  // An exception always redirects, even when stalled, but never touches the
  // stack beyond clearing it.
  assign w_advance = ~stall | exc_valid;
  assign w_push    = ~stall & ~exc_valid & w_is_abs & link;
  assign w_pop     = ~stall & ~exc_valid & w_ret_hit;

  // --------------------------------------------------------------------------
  // PC register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (w_advance) begin
      r_pc <= npc;
    end
  end

  // --------------------------------------------------------------------------
  // RAS bookkeeping
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (exc_valid) begin
      r_sp    <= '0;
      r_count <= '0;
    end else if (w_push) begin
      // Circular pointer: pushing onto a full stack drops the oldest entry.
      r_sp <= r_sp + c_PTR_ONE;
      if (w_full) begin
        r_overflow <= 1'b1;
      end else begin
        r_count <= r_count + c_CNT_ONE;
      end
    end else if (w_pop) begin
      r_sp    <= r_sp - c_PTR_ONE;
      r_count <= r_count - c_CNT_ONE;
    end
  end

  // Storage needs no reset: entries are only read while r_count says valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ras[r_sp] <= w_pc_plus4;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pc           = r_pc;
  assign ras_empty    = w_empty;
  assign ras_full     = w_full;
  assign ras_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Directed-vector bench for pc_unit. A driver applies one vector
//               per cycle and queues the hand-computed PC and RAS flags that
//               must appear after the next rising edge; a monitor pops and
//               compares them after every edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        exc_valid;
  logic [31:0] exc_vector;
  logic [1:0]  jump_ctrl;
  logic [2:0]  branch_ctrl;
  logic        zero;
  logic        sign;
  logic [31:0] imm32;
  logic [25:0] target;
  logic [31:0] reg_target;
  logic        link;
  logic        ret;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_overflow;

  pc_unit #(
    .WIDTH    (32),
    .RESET_PC (32'h0000_3000),
    .JUMP_BASE(32'h0000_3000),
    .RAS_DEPTH(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .exc_valid   (exc_valid),
    .exc_vector  (exc_vector),
    .jump_ctrl   (jump_ctrl),
    .branch_ctrl (branch_ctrl),
    .zero        (zero),
    .sign        (sign),
    .imm32       (imm32),
    .target      (target),
    .reg_target  (reg_target),
    .link        (link),
    .ret         (ret),
    .pc          (pc),
    .npc         (npc),
    .ras_empty   (ras_empty),
    .ras_full    (ras_full),
    .ras_overflow(ras_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  fl;   // {ras_empty, ras_full, ras_overflow}
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [31:0] act_pc, input logic [2:0] act_fl,
                       input logic [31:0] exp_pc, input logic [2:0] exp_fl);
    n_vec++;
    if (act_pc !== exp_pc || act_fl !== exp_fl) begin
      n_err++;
      $display("FAIL %s: pc=%h flags(e,f,o)=%b, required pc=%h flags=%b",
               nm, act_pc, act_fl, exp_pc, exp_fl);
    end
  endtask

  // Monitor: the PC is a valid output after every rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check(e.name, pc, {ras_empty, ras_full, ras_overflow}, e.pc, e.fl);
    end
  end

  task automatic apply(input logic st, input logic ex, input logic [31:0] ev,
                       input logic [1:0] jc, input logic [2:0] bc,
                       input logic z, input logic s, input logic [31:0] im,
                       input logic [25:0] tg, input logic [31:0] rt,
                       input logic lk, input logic rtn,
                       input logic [31:0] epc, input logic [2:0] efl, input string nm);
    exp_t e;
    @(negedge clk);
    stall = st; exc_valid = ex; exc_vector = ev;
    jump_ctrl = jc; branch_ctrl = bc; zero = z; sign = s; imm32 = im;
    target = tg; reg_target = rt; link = lk; ret = rtn;
    e.pc = epc; e.fl = efl; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic idle(input logic [31:0] epc, input logic [2:0] efl, input string nm);
    apply(0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 0, epc, efl, nm);
  endtask

  task automatic call(input logic [25:0] tg, input logic [31:0] epc,
                      input logic [2:0] efl, input string nm);
    apply(0, 0, 0, 2'b01, 3'b000, 0, 0, 0, tg, 0, 1, 0, epc, efl, nm);
  endtask

  task automatic retn(input logic [31:0] rt, input logic [31:0] epc,
                      input logic [2:0] efl, input string nm);
    apply(0, 0, 0, 2'b10, 3'b000, 0, 0, 0, 0, rt, 0, 1, epc, efl, nm);
  endtask

  // Taken table per branch code 1..7, bit index = {zero, sign}.
  logic [3:0] taken_tbl [7];
  initial begin
    taken_tbl[0] = 4'b1100; // 001 eq
    taken_tbl[1] = 4'b0011; // 010 ne
    taken_tbl[2] = 4'b1110; // 011 >=0
    taken_tbl[3] = 4'b0001; // 100 <0
    taken_tbl[4] = 4'b0010; // 101 >0
    taken_tbl[5] = 4'b1101; // 110 <=0
    taken_tbl[6] = 4'b0000; // 111 none
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  localparam logic [2:0] F_E   = 3'b100;   // empty
  localparam logic [2:0] F_N   = 3'b000;   // non-empty
  localparam logic [2:0] F_F   = 3'b010;   // full
  localparam logic [2:0] F_FO  = 3'b011;   // full + overflow
  localparam logic [2:0] F_NO  = 3'b001;   // non-empty + overflow
  localparam logic [2:0] F_EO  = 3'b101;   // empty + overflow

  initial begin
    logic [31:0] p;
    logic [1:0]  zs;
    logic        tk;
    rst_n = 1'b0; stall = 0; exc_valid = 0; exc_vector = 0; jump_ctrl = 0;
    branch_ctrl = 0; zero = 0; sign = 0; imm32 = 0; target = 0;
    reg_target = 0; link = 0; ret = 0;

    #12;
    check("reset_state", pc, {ras_empty, ras_full, ras_overflow}, 32'h3000, F_E);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;

    idle(32'h3004, F_E, "seq_3004");
    idle(32'h3008, F_E, "seq_3008");
    idle(32'h300C, F_E, "seq_300C");
    idle(32'h3010, F_E, "seq_3010");
    apply(0, 0, 0, 2'b00, 3'b001, 1, 0, 32'hFFFF_FFFE, 0, 0, 0, 0, 32'h3008, F_E, "beq_taken_back");
    idle(32'h300C, F_E, "seq_300C_b");
    idle(32'h3010, F_E, "seq_3010_b");
    apply(0, 0, 0, 2'b00, 3'b001, 0, 0, 32'hFFFF_FFFE, 0, 0, 0, 0, 32'h3014, F_E, "beq_not_taken");

    p = 32'h3014;
    for (int c = 1; c <= 7; c++) begin
      for (int k = 0; k < 4; k++) begin
        zs = 2'(k);
        tk = taken_tbl[c-1][k];
        p  = tk ? p + 32'd16 : p + 32'd4;
        apply(0, 0, 0, 2'b00, 3'(c), zs[1], zs[0], 32'd4, 0, 0, 0, 0, p, F_E,
              $sformatf("branch_%0d_z%0d_s%0d", c, zs[1], zs[0]));
      end
    end

    // Reserved jump code must let the branch through.
    p = p + 32'd16;
    apply(0, 0, 0, 2'b11, 3'b001, 1, 0, 32'd4, 0, 0, 0, 0, p, F_E, "jump11_branch");
    // Absolute jump overrides a taken branch: 3000 + (8<<2) = 3020.
    apply(0, 0, 0, 2'b01, 3'b001, 1, 0, 32'd4, 26'h8, 0, 0, 0, 32'h3020, F_E, "jump_over_branch");

    call(26'h40, 32'h3100, F_N, "call_3100");
    idle(32'h3104, F_N, "seq_3104");
    retn(32'h500, 32'h3024, F_E, "ret_3024");

    call(26'h100, 32'h3400, F_N, "wrap_call1");
    call(26'h110, 32'h3440, F_N, "wrap_call2");
    call(26'h120, 32'h3480, F_N, "wrap_call3");
    call(26'h130, 32'h34C0, F_F, "wrap_call4");
    call(26'h140, 32'h3500, F_FO, "wrap_call5");
    retn(32'h500, 32'h34C4, F_NO, "wrap_pop1");
    retn(32'h500, 32'h3484, F_NO, "wrap_pop2");
    retn(32'h500, 32'h3444, F_NO, "wrap_pop3");
    retn(32'h500, 32'h3404, F_EO, "wrap_pop4");
    retn(32'h8,   32'h3008, F_EO, "pop_empty_regjump");
    apply(0, 0, 0, 2'b10, 3'b000, 0, 0, 0, 0, 32'h44, 0, 0, 32'h3044, F_EO, "regjump_3044");

    call(26'h10, 32'h3040, F_NO, "call_3040");
    apply(1, 0, 0, 2'b01, 3'b000, 0, 0, 0, 26'h50, 0, 1, 0, 32'h3040, F_NO, "stall_jump");
    apply(1, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 0, 32'h3040, F_NO, "stall_idle");
    apply(1, 1, 32'h80, 2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 0, 32'h80, F_EO, "stall_exc");
    retn(32'h0, 32'h3000, F_EO, "ret_after_exc");
    apply(0, 1, 32'h200, 2'b01, 3'b000, 0, 0, 0, 26'h10, 0, 1, 0, 32'h200, F_EO, "exc_over_call");
    idle(32'h204, F_EO, "seq_204");

    // Asynchronous reset between edges.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", pc, {ras_empty, ras_full, ras_overflow}, 32'h3000, F_E);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(32'h3004, F_E, "post_reset_3004");
    idle(32'h3008, F_E, "post_reset_3008");

    @(posedge clk);
    #3;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
